// File: rtl/cmp_pkg.sv
// cmp_pkg: shared FSM states, default widths and the result record for cmp_frame_stats.
//   CMP_DW / CMP_FRAME_LEN / CMP_CW : default sample width, frame length, counter width
//   cmp_state_t                     : IDLE -> ACCUM -> DONE
//   cmp_rec_t                       : gt/lt/eq counts plus frame max/min (default sizes)
package cmp_pkg;
    localparam int CMP_DW        = 4;
    localparam int CMP_FRAME_LEN = 8;
    localparam int CMP_CW        = $clog2(CMP_FRAME_LEN + 1);
    typedef enum logic [1:0] {CMP_IDLE, CMP_ACCUM, CMP_DONE} cmp_state_t;
    typedef struct packed {
        logic [CMP_CW-1:0] gt;
        logic [CMP_CW-1:0] lt;
        logic [CMP_CW-1:0] eq;
        logic [CMP_DW-1:0] mx;
        logic [CMP_DW-1:0] mn;
    } cmp_rec_t;
endpackage

// File: rtl/cmp_frame_stats_cmp4.sv
// Comparator4bit: unsigned magnitude comparator, one-hot greater/smaller/equal.
//   a, b    : operands (W bits, unsigned)
//   greater : a > b,  smaller : a < b,  equal : a == b
module Comparator4bit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [0:0]   greater,
    output logic [0:0]   smaller,
    output logic [0:0]   equal
);
    assign greater = a > b;
    assign smaller = a < b;
    assign equal   = a == b;
endmodule

// File: rtl/cmp_frame_stats.sv
// cmp_frame_stats: per-frame compare-against-reference statistics (gt/lt/eq counts, max, min).
//   clk, rst_n            : clock, async active-low reset
//   start, ref_data       : begin a frame in IDLE, latching the reference
//   in_valid/in_ready/in_data   : sample stream, accepted only in ACCUM
//   out_valid/out_ready   : result record handshake, valid in DONE
//   gt_cnt/lt_cnt/eq_cnt, max_val/min_val : frame results, held until next accepted start
//   busy                  : high in ACCUM or DONE
module cmp_frame_stats
    import cmp_pkg::*;
#(
    parameter  int DW        = CMP_DW,
    parameter  int FRAME_LEN = CMP_FRAME_LEN,
    localparam int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] ref_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] gt_cnt,
    output logic [CW-1:0] lt_cnt,
    output logic [CW-1:0] eq_cnt,
    output logic [DW-1:0] max_val,
    output logic [DW-1:0] min_val,
    output logic          busy
);
    cmp_state_t    r_state, w_next;
    logic [DW-1:0] r_ref, r_max, r_min;
    logic [CW-1:0] r_gt, r_lt, r_eq, r_idx;
    logic [0:0]    w_gt, w_lt, w_eq;
    logic          w_start, w_hs, w_last;

    Comparator4bit #(.W(DW)) u_cmp (
        .a       (in_data),
        .b       (r_ref),
        .greater (w_gt),
        .smaller (w_lt),
        .equal   (w_eq)
    );

    assign w_start = (r_state == CMP_IDLE) && start;
    assign w_hs    = (r_state == CMP_ACCUM) && in_valid;
    assign w_last  = w_hs && (r_idx == CW'(FRAME_LEN - 1));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= CMP_IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (w_start) w_next = CMP_ACCUM;
        if (w_last) w_next = CMP_DONE;
        if (r_state == CMP_DONE && out_ready) w_next = CMP_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_ref <= '0;
            r_gt  <= '0;
            r_lt  <= '0;
            r_eq  <= '0;
            r_idx <= '0;
            r_max <= '0;
            r_min <= '1;
        end else if (w_start) begin
            r_ref <= ref_data;
            r_gt  <= '0;
            r_lt  <= '0;
            r_eq  <= '0;
            r_idx <= '0;
            r_max <= '0;
            r_min <= '1;
        end else if (w_hs) begin
            // comparator outputs are one-hot, so exactly one count advances
            r_gt  <= r_gt + CW'(w_gt[0]);
            r_lt  <= r_lt + CW'(w_lt[0]);
            r_eq  <= r_eq + CW'(w_eq[0]);
            r_idx <= r_idx + CW'(1);
            if (in_data > r_max) r_max <= in_data;
            if (in_data < r_min) r_min <= in_data;
        end

    assign in_ready  = r_state == CMP_ACCUM;
    assign out_valid = r_state == CMP_DONE;
    assign busy      = r_state != CMP_IDLE;
    assign gt_cnt    = r_gt;
    assign lt_cnt    = r_lt;
    assign eq_cnt    = r_eq;
    assign max_val   = r_max;
    assign min_val   = r_min;
endmodule

// File: tb/tb_cmp_frame_stats.sv
// tb_cmp_frame_stats: scoreboard bench for cmp_frame_stats (default DW=4, FRAME_LEN=8).
module tb_cmp_frame_stats;
    import cmp_pkg::*;
    localparam int DW = CMP_DW;
    localparam int FL = CMP_FRAME_LEN;
    localparam int CW = CMP_CW;

    logic          clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
    logic [DW-1:0] ref_data = '0, in_data = '0;
    logic          in_ready, out_valid, busy;
    logic [CW-1:0] gt_cnt, lt_cnt, eq_cnt;
    logic [DW-1:0] max_val, min_val;
    cmp_rec_t      q[$];
    int            n_cmp = 0, n_bad = 0;
    logic [DW-1:0] s [FL];

    cmp_frame_stats #(.DW(DW), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ref_data  (ref_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt_cnt    (gt_cnt),
        .lt_cnt    (lt_cnt),
        .eq_cnt    (eq_cnt),
        .max_val   (max_val),
        .min_val   (min_val),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_counts"}, {gt_cnt, lt_cnt, eq_cnt}, 0);
        chk({tag, "_max"}, max_val, 0);
        chk({tag, "_min"}, min_val, {DW{1'b1}});
    endtask

    task automatic chk_rec(input string tag, input cmp_rec_t e);
        chk({tag, "_gt"}, gt_cnt, e.gt);
        chk({tag, "_lt"}, lt_cnt, e.lt);
        chk({tag, "_eq"}, eq_cnt, e.eq);
        chk({tag, "_max"}, max_val, e.mx);
        chk({tag, "_min"}, min_val, e.mn);
        chk({tag, "_sum"}, 32'(gt_cnt) + 32'(lt_cnt) + 32'(eq_cnt), FL);
    endtask

    task automatic send_frame(input logic [DW-1:0] r, input logic [DW-1:0] smp [FL],
                              input bit bub, input bit glitch);
        cmp_rec_t e;
        int       i;
        bit       ph;
        e    = '0;
        e.mn = '1;
        for (int k = 0; k < FL; k++) begin
            if (smp[k] > r) e.gt = e.gt + 1'b1;
            else if (smp[k] < r) e.lt = e.lt + 1'b1;
            else e.eq = e.eq + 1'b1;
            if (smp[k] > e.mx) e.mx = smp[k];
            if (smp[k] < e.mn) e.mn = smp[k];
        end
        q.push_back(e);
        start    = 1;
        ref_data = r;
        tick;
        start = 0;
        chk("in_ready_after_start", in_ready, 1);
        chk("busy_accum", busy, 1);
        i  = 0;
        ph = 0;
        while (i < FL) begin
            in_valid = bub ? ph : 1'b1;
            ph       = !ph;
            in_data  = smp[i];
            if (glitch && i == 3) begin
                start    = 1;
                ref_data = ~r;
            end
            tick;
            start = 0;
            if (in_valid) i++;
        end
        in_valid = 0;
        chk("out_valid_after_last", out_valid, 1);
        chk("in_ready_done", in_ready, 0);
    endtask

    task automatic collect(input int hold, input bit glitch);
        cmp_rec_t e;
        int       t;
        t = 0;
        while (!out_valid && t < 50) begin
            tick;
            t++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", out_valid, 1);
            return;
        end
        if (q.size() == 0) begin
            chk("sb_underflow", 32'(q.size()), 1);
            return;
        end
        e         = q.pop_front();
        out_ready = 0;
        for (int k = 0; k < hold; k++) begin
            if (glitch && k == 1) begin
                start    = 1;
                ref_data = ref_data + 4'd3;
            end
            chk_rec("hold", e);
            chk("out_valid_hold", out_valid, 1);
            tick;
            start = 0;
        end
        chk_rec("result", e);
        out_ready = 1;
        tick;
        out_ready = 0;
        chk("out_valid_after_hs", out_valid, 0);
        chk("busy_after_hs", busy, 0);
        chk_rec("kept", e);
    endtask

    initial begin
        repeat (3) tick;
        chk_idle_reset("reset");
        rst_n    = 1;
        in_valid = 1;
        repeat (3) begin
            tick;
            chk("no_start_in_ready", in_ready, 0);
            chk("no_start_busy", busy, 0);
            chk("no_start_counts", {gt_cnt, lt_cnt, eq_cnt}, 0);
        end
        in_valid = 0;
        tick;

        s = '{4'd0, 4'd7, 4'd8, 4'd15, 4'd7, 4'd3, 4'd9, 4'd7};
        send_frame(4'b0111, s, 0, 0);
        collect(0, 0);
        send_frame(4'b0111, s, 1, 0);
        collect(5, 0);
        send_frame(4'b0111, s, 0, 1);
        collect(5, 1);

        s = '{default: 4'd0};
        send_frame(4'b0000, s, 0, 0);
        collect(1, 0);
        s = '{default: 4'd15};
        send_frame(4'b1111, s, 0, 0);
        collect(1, 0);

        start    = 1;
        ref_data = 4'd5;
        tick;
        start = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1;
            in_data  = 4'(k * 3 + 2);
            tick;
        end
        in_valid = 0;
        chk("mid_busy", busy, 1);
        rst_n = 0;
        #1;
        chk_idle_reset("async_reset");
        tick;
        rst_n = 1;
        tick;

        for (int k = 0; k < FL; k++) s[k] = 4'($urandom_range(0, 15));
        send_frame(4'($urandom_range(0, 15)), s, 1, 0);
        collect(2, 0);
        for (int k = 0; k < FL; k++) s[k] = 4'($urandom_range(0, 15));
        send_frame(4'($urandom_range(0, 15)), s, 0, 0);
        collect(0, 0);

        chk("sb_empty", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
